// File: rtl/xcvr_init_pkg.sv
// Shared definitions for the transceiver reference-clock bring-up sequencer:
// state encoding, default cycle counts and the retry counter width.
package xcvr_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STARTUP   = 3'd1,
    ST_PLL_RST   = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_STABLE    = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  localparam int unsigned DEF_STARTUP_CYCLES = 1024;
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 65535;
  localparam int unsigned DEF_LOCK_STABLE    = 256;
  localparam int unsigned DEF_MAX_RETRIES    = 3;
  localparam int unsigned DEF_CNT_W          = 16;

  localparam int unsigned RETRY_W = 2;

endpackage

// File: rtl/xcvr_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   i_clk - destination clock
//   i_rst - asynchronous active-high reset, clears both flops
//   i_d   - asynchronous input
//   o_q   - i_d delayed by two i_clk cycles
module xcvr_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/xcvr_refclk_init_seq.sv
// Transceiver bring-up sequencer running on REF_CLK. Waits for the reference
// clock to settle, pulses the TX PLL reset, waits for lock (with timeout and
// bounded retries), requires a stable lock window, then releases the lane.
// Lock loss while running restarts the PLL reset sequence.
// Ports:
//   CLK         - REF_CLK, sole clock
//   RESET       - asynchronous active-high reset
//   START       - level enable; low forces IDLE
//   PLL_LOCK    - asynchronous TX PLL lock
//   PLL_RESETN  - active-low TX PLL reset
//   LANE_RESETN - active-low lane PCS/PMA reset
//   INIT_DONE   - lane released and lock held
//   INIT_FAIL   - retries exhausted
//   STATE       - current state encoding (debug)
//   RETRY_CNT   - timeouts since the last successful lock
module xcvr_refclk_init_seq
  import xcvr_init_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = DEF_STARTUP_CYCLES,
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               PLL_LOCK,
  output logic               PLL_RESETN,
  output logic               LANE_RESETN,
  output logic               INIT_DONE,
  output logic               INIT_FAIL,
  output logic [2:0]         STATE,
  output logic [RETRY_W-1:0] RETRY_CNT
);

  localparam logic [CNT_W-1:0]   STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_pll_resetn;
  logic               r_lane_en;
  logic               r_fail;

  state_t             w_next;
  logic [RETRY_W-1:0] w_retry_next;
  logic               w_lock_s;

  xcvr_sync2 u_lock_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (PLL_LOCK),
    .o_q   (w_lock_s)
  );

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    case (r_state)
      ST_IDLE: begin
        w_retry_next = '0;
        if (START) w_next = ST_STARTUP;
      end
      ST_STARTUP: begin
        if (r_cnt == STARTUP_LAST) w_next = ST_PLL_RST;
      end
      ST_PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock is checked first so a lock arriving on the timeout cycle wins.
        if (w_lock_s) begin
          w_next = ST_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry == RETRY_LAST) begin
            w_next = ST_FAIL;
          end else begin
            w_retry_next = r_retry + 1'b1;
            w_next       = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_next       = ST_RUN;
          w_retry_next = '0;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) w_next = ST_PLL_RST;
      end
      ST_FAIL: begin
        w_next = ST_FAIL;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    if (!START) begin
      w_next       = ST_IDLE;
      w_retry_next = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // change in the same cycle as STATE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_pll_resetn <= 1'b0;
      r_lane_en    <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_retry      <= w_retry_next;
      r_cnt        <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_pll_resetn <= (w_next inside {ST_WAIT_LOCK, ST_STABLE, ST_RUN});
      r_lane_en    <= (w_next == ST_RUN);
      r_fail       <= (w_next == ST_FAIL);
    end
  end

  assign STATE       = r_state;
  assign RETRY_CNT   = r_retry;
  assign PLL_RESETN  = r_pll_resetn;
  assign LANE_RESETN = r_lane_en;
  assign INIT_DONE   = r_lane_en;
  assign INIT_FAIL   = r_fail;

endmodule

// File: tb/tb_xcvr_refclk_init_seq.sv
module tb_xcvr_refclk_init_seq;

  localparam int SC = 8;
  localparam int PR = 4;
  localparam int TO = 20;
  localparam int ST = 5;
  localparam int MR = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       lock  = 1'b0;
  logic       pll_resetn, lane_resetn, init_done, init_fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  xcvr_refclk_init_seq #(
    .STARTUP_CYCLES (SC),
    .PLL_RST_CYCLES (PR),
    .LOCK_TIMEOUT   (TO),
    .LOCK_STABLE    (ST),
    .MAX_RETRIES    (MR),
    .CNT_W          (16)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .START       (start),
    .PLL_LOCK    (lock),
    .PLL_RESETN  (pll_resetn),
    .LANE_RESETN (lane_resetn),
    .INIT_DONE   (init_done),
    .INIT_FAIL   (init_fail),
    .STATE       (state),
    .RETRY_CNT   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus remaining cycles in that phase, and a
  // two-entry lock history standing in for the synchroniser delay.
  int   m_phase = 0;
  int   m_rem   = 0;
  int   m_retry = 0;
  logic m_h0    = 1'b0;
  logic m_h1    = 1'b0;

  task automatic m_enter(input int ph, input int dur);
    m_phase = ph;
    m_rem   = dur;
  endtask

  task automatic m_reset();
    m_phase = 0; m_rem = 0; m_retry = 0; m_h0 = 1'b0; m_h1 = 1'b0;
  endtask

  task automatic m_edge(input logic st, input logic lk);
    logic ls;
    ls   = m_h1;
    m_h1 = m_h0;
    m_h0 = lk;
    if (!st) begin
      m_phase = 0;
      m_retry = 0;
      return;
    end
    case (m_phase)
      0: m_enter(1, SC);
      1: begin m_rem--; if (m_rem == 0) m_enter(2, PR); end
      2: begin m_rem--; if (m_rem == 0) m_enter(3, TO); end
      3: begin
        if (ls) m_enter(4, ST);
        else begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_retry + 1 >= MR) m_enter(6, 0);
            else begin m_retry++; m_enter(2, PR); end
          end
        end
      end
      4: begin
        if (!ls) m_enter(3, TO);
        else begin
          m_rem--;
          if (m_rem == 0) begin m_enter(5, 0); m_retry = 0; end
        end
      end
      5: if (!ls) m_enter(2, PR);
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_edge(start, lock);
  end

  // Single compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("cycle_outputs",
        int'({state, retry_cnt, pll_resetn, lane_resetn, init_done, init_fail}),
        int'({3'(m_phase), 2'(m_retry),
              (m_phase >= 3 && m_phase <= 5) ? 1'b1 : 1'b0,
              (m_phase == 5) ? 1'b1 : 1'b0,
              (m_phase == 5) ? 1'b1 : 1'b0,
              (m_phase == 6) ? 1'b1 : 1'b0}));
  end

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(state), s);
  endtask

  initial begin
    int n;
    int seen;
    int r0;
    int lane_seen;
    int lock_run;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_resets", int'({pll_resetn, lane_resetn, init_done, init_fail}), 0);
    chk("reset_retry", int'(retry_cnt), 0);

    // Nominal bring-up
    start = 1'b1;
    wait_state(1, 5, "enter_startup");
    n = 0;
    while (!pll_resetn && n < 100) begin @(negedge clk); n++; end
    chk("startup_to_pll_release", n, 12);
    @(negedge clk);
    lock = 1'b1;
    n = 0;
    while (!lane_resetn && n < 100) begin @(negedge clk); n++; end
    chk("lock_to_lane_release", n, 8);
    chk("done_with_lane", int'(init_done), 1);
    chk("nominal_retry", int'(retry_cnt), 0);

    // Lock loss in RUN
    repeat (3) @(negedge clk);
    lock = 1'b0;
    n = 0;
    while (init_done && n < 20) begin @(negedge clk); n++; end
    chk("lockloss_latency", n, 3);
    chk("lockloss_state", int'(state), 2);
    chk("lockloss_lane", int'(lane_resetn), 0);
    n = 0;
    while (!pll_resetn && n < 50) begin n++; @(negedge clk); end
    chk("lockloss_pll_low_cycles", n, 4);

    // START low during WAIT_LOCK
    chk("in_wait_lock", int'(state), 3);
    start = 1'b0;
    @(negedge clk);
    chk("start_low_state", int'(state), 0);
    chk("start_low_pll", int'(pll_resetn), 0);

    // PLL never locks: retries then FAIL
    start = 1'b1;
    n = 0;
    while (!pll_resetn && n < 40) begin @(negedge clk); n++; end
    chk("nolock_pll_release", int'(pll_resetn), 1);
    n = 0;
    seen = 0;
    while (!init_fail && n < 200) begin
      seen |= (1 << retry_cnt);
      @(negedge clk);
      n++;
    end
    chk("fail_latency", n, 68);
    chk("retry_values_seen", seen, 7);
    chk("fail_resets_low", int'({pll_resetn, lane_resetn}), 0);
    repeat (3) @(negedge clk);
    chk("fail_holds", int'({state, init_fail}), 13);
    start = 1'b0;
    @(negedge clk);
    chk("fail_exit", int'({state, init_fail}), 0);

    // Lock glitch in STABLE
    start = 1'b1;
    lock  = 1'b1;
    wait_state(4, 60, "reach_stable");
    r0 = int'(retry_cnt);
    repeat (2) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    seen = 0;
    lane_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (state == 3'd3) seen = 1;
      if (seen == 0 && lane_resetn) lane_seen = 1;
    end
    chk("glitch_back_to_wait", seen, 1);
    chk("glitch_retry_kept", int'(retry_cnt), r0);
    chk("glitch_lane_low", lane_seen, 0);
    n = 0;
    while (!lane_resetn && n < 30) begin @(negedge clk); n++; end
    chk("glitch_recovers", int'(lane_resetn), 1);

    // Asynchronous reset during STABLE
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_state(4, 60, "reach_stable_2");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        int'({state, retry_cnt, pll_resetn, lane_resetn, init_done, init_fail}), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!lane_resetn && n < 60) begin @(negedge clk); n++; end
    chk("restart_after_reset", int'(lane_resetn), 1);

    // Randomised stimulus against the model
    lock_run = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (lock_run == 0) begin
        lock     = ($urandom_range(3) != 0);
        lock_run = lock ? $urandom_range(60, 1) : $urandom_range(30, 1);
      end
      lock_run--;
      if (!start) start = 1'b1;
      else if ($urandom_range(249) == 0) start = 1'b0;
      if ($urandom_range(599) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xcvr_refclk_init_seq.md
Name: xcvr_refclk_init_seq

Overview:
- Transceiver bring-up sequencer clocked directly by REF_CLK, the output of the XCVR reference-clock input buffer.
- Waits for the reference clock to run stably, then releases the TX PLL reset, waits for PLL lock with timeout and retry, then releases the lane reset.
- Supervises lock during operation and re-initialises on lock loss.
- Sits between the reference-clock buffer and the PF_XCVR lane / TX PLL reset inputs.

Parameters:
- STARTUP_CYCLES, 1024: REF_CLK cycles waited after START before any reset is released.
- PLL_RST_CYCLES, 16: cycles PLL_RESETN is held low in PLL_RST.
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before a timeout.
- LOCK_STABLE, 256: consecutive synchronised-lock cycles required before lane release.
- MAX_RETRIES, 3: timeouts tolerated before entering FAIL.
- CNT_W, 16: width of the shared cycle counter; must hold the largest cycle parameter.

Ports:
- CLK  input  1  REF_CLK from the reference-clock buffer; sole clock.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  level enable, synchronous to CLK; low forces IDLE.
- PLL_LOCK  input  1  TX PLL lock, asynchronous; passed through an internal 2-flop synchroniser.
- PLL_RESETN  output  1  active-low TX PLL reset.
- LANE_RESETN  output  1  active-low lane PCS/PMA reset.
- INIT_DONE  output  1  lane released and lock held.
- INIT_FAIL  output  1  retries exhausted.
- STATE  output  3  current state encoding, for debug.
- RETRY_CNT  output  2  timeouts since the last successful lock.

Behaviour:
- Reset values: PLL_RESETN=0, LANE_RESETN=0, INIT_DONE=0, INIT_FAIL=0, STATE=IDLE(0), RETRY_CNT=0. The counter and synchroniser flops also reset to 0.
- All outputs are registered. lock_s is PLL_LOCK delayed by 2 CLK cycles.
- One shared counter cnt (CNT_W bits). It is cleared on every state transition and increments by 1 each cycle otherwise. Comparisons are against parameter-1.
- IDLE(0): PLL_RESETN=0, LANE_RESETN=0, RETRY_CNT=0. If START=1, go to STARTUP.
- STARTUP(1): when cnt = STARTUP_CYCLES-1, go to PLL_RST.
- PLL_RST(2): PLL_RESETN=0. When cnt = PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK(3): PLL_RESETN=1.
  - If lock_s=1, go to STABLE.
  - Else if cnt = LOCK_TIMEOUT-1, it is a timeout: if RETRY_CNT = MAX_RETRIES-1, go to FAIL; otherwise RETRY_CNT+1 and go to PLL_RST.
- STABLE(4): PLL_RESETN=1.
  - If lock_s=0, return to WAIT_LOCK. cnt clears; the timeout window restarts; RETRY_CNT is unchanged.
  - If cnt = LOCK_STABLE-1 with lock_s=1, go to RUN.
- RUN(5): PLL_RESETN=1, LANE_RESETN=1, INIT_DONE=1. RETRY_CNT clears on entry.
  - If lock_s=0, go to PLL_RST. In the same registered update LANE_RESETN=0 and INIT_DONE=0.
- FAIL(6): PLL_RESETN=0, LANE_RESETN=0, INIT_FAIL=1. The block stays in FAIL until START=0, then goes to IDLE and INIT_FAIL clears.
- START=0 in any state: next state is IDLE. This has priority over all other transitions.
- Simultaneous lock_s rise and timeout in WAIT_LOCK: lock wins; go to STABLE.
- LANE_RESETN is 1 only in RUN. INIT_DONE and LANE_RESETN always change in the same cycle.
- Asynchronous RESET mid-sequence: every flop returns to its reset value immediately. The sequence restarts from IDLE after deassertion.
- Encoding 7 is unused: next state IDLE.

Decomposition:
- Shared package xcvr_init_pkg:
  - state enum (IDLE..FAIL, 3-bit).
  - default cycle constants.
  - RETRY_CNT width constant.
- Sub-module xcvr_sync2: a 2-flop synchroniser with asynchronous active-high reset to 0, used for PLL_LOCK.
- The FSM, counter and outputs stay in the top module.

Test Plan:
- Bench parameters: STARTUP=8, PLL_RST=4, TIMEOUT=20, STABLE=5, RETRIES=3.
- Nominal: START=1 at t0, PLL_LOCK=1 from 2 cycles after PLL_RESETN rises.
  - PLL_RESETN rises 12 cycles after STATE leaves IDLE.
  - LANE_RESETN and INIT_DONE rise 2+1+5 cycles later.
  - RETRY_CNT=0.
- PLL_LOCK tied 0:
  - RETRY_CNT steps 1, 2.
  - INIT_FAIL=1 after the third 20-cycle timeout, with both resets low.
  - START=0 then returns STATE=0 and INIT_FAIL=0.
- Lock glitch in STABLE: lock low 1 cycle after 3 stable cycles → STATE returns to WAIT_LOCK, RETRY_CNT unchanged, LANE_RESETN stays 0.
- Lock loss in RUN: PLL_LOCK falls → within 3 cycles INIT_DONE=0, LANE_RESETN=0, STATE=PLL_RST, PLL_RESETN=0 for 4 cycles.
- START=0 during WAIT_LOCK → next cycle STATE=IDLE, PLL_RESETN=0.
- Reset mid-sequence: RESET pulse during STABLE (asynchronous, mid-cycle) → all outputs go to reset values without waiting for a clock edge. The sequence restarts and completes normally.
